// File: rtl/xy_router_wh.sv
// Wormhole XY route decoder: routes on the head flit, locks the route until the tail,
// one-entry registered output stage. Define XY_ROUTER_YX_FIRST_EN for YX dimension order.
module xy_router_wh #(
  parameter int X_CORD          = 0,
  parameter int Y_CORD          = 0,
  parameter int PACKET_ADDR_X_W = 4,
  parameter int PACKET_ADDR_Y_W = 4,
  parameter int FLIT_W          = 16,
  parameter int OUTPUT_N_W      = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [FLIT_W-1:0]     flit_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [FLIT_W-1:0]     flit_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUTPUT_N_W-1:0] mux_out_sel_o,
  output logic                  last_o,
  output logic                  err_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PKT  = 1'b1;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  localparam logic [OUTPUT_N_W-1:0] DIR_RES   = OUTPUT_N_W'(0);
  localparam logic [OUTPUT_N_W-1:0] DIR_WEST  = OUTPUT_N_W'(1);
  localparam logic [OUTPUT_N_W-1:0] DIR_EAST  = OUTPUT_N_W'(2);
  localparam logic [OUTPUT_N_W-1:0] DIR_NORTH = OUTPUT_N_W'(3);
  localparam logic [OUTPUT_N_W-1:0] DIR_SOUTH = OUTPUT_N_W'(4);

  localparam logic [PACKET_ADDR_X_W-1:0] X_LOC = PACKET_ADDR_X_W'(X_CORD);
  localparam logic [PACKET_ADDR_Y_W-1:0] Y_LOC = PACKET_ADDR_Y_W'(Y_CORD);

  logic [0:0]            state_q, state_d;
  logic [OUTPUT_N_W-1:0] route_q, route_d;
  logic                  valid_q, valid_d;
  logic [FLIT_W-1:0]     flit_q, flit_d;
  logic [OUTPUT_N_W-1:0] sel_q, sel_d;
  logic                  last_q, last_d;
  logic                  err_q, err_d;

  logic [PACKET_ADDR_X_W-1:0] x_addr;
  logic [PACKET_ADDR_Y_W-1:0] y_addr;
  logic [1:0]                 flit_type;
  logic [OUTPUT_N_W-1:0]      dir;
  logic                       in_xfer;

  assign ready_o = !valid_q || ready_i;
  assign in_xfer = valid_i && ready_o;

  always_comb begin
    x_addr    = flit_i[PACKET_ADDR_X_W-1:0];
    y_addr    = flit_i[PACKET_ADDR_X_W+PACKET_ADDR_Y_W-1:PACKET_ADDR_X_W];
    flit_type = flit_i[FLIT_W-1:FLIT_W-2];
    dir       = DIR_RES;
`ifdef XY_ROUTER_YX_FIRST_EN
    if (y_addr > Y_LOC)      dir = DIR_NORTH;
    else if (y_addr < Y_LOC) dir = DIR_SOUTH;
    else if (x_addr > X_LOC) dir = DIR_EAST;
    else if (x_addr < X_LOC) dir = DIR_WEST;
`else
    if (x_addr > X_LOC)      dir = DIR_EAST;
    else if (x_addr < X_LOC) dir = DIR_WEST;
    else if (y_addr > Y_LOC) dir = DIR_NORTH;
    else if (y_addr < Y_LOC) dir = DIR_SOUTH;
`endif
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    valid_d = valid_q && !ready_i;
    flit_d  = flit_q;
    sel_d   = sel_q;
    last_d  = last_q;
    err_d   = 1'b0;
    if (in_xfer) begin
      if (state_q == IDLE) begin
        case (flit_type)
          T_HEAD: begin
            route_d = dir;
            valid_d = 1'b1; flit_d = flit_i; sel_d = dir; last_d = 1'b0;
            state_d = PKT;
          end
          T_SINGLE: begin
            valid_d = 1'b1; flit_d = flit_i; sel_d = dir; last_d = 1'b1;
          end
          default: err_d = 1'b1;
        endcase
      end else begin
        // A stray head/single mid-packet is retyped so downstream sees a well-formed worm.
        valid_d = 1'b1;
        sel_d   = route_q;
        flit_d  = flit_i;
        last_d  = flit_type[0];
        if (flit_type[1]) begin
          err_d  = 1'b1;
          flit_d = {1'b0, flit_type[0], flit_i[FLIT_W-3:0]};
        end
        if (flit_type[0]) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      route_q <= '0;
      valid_q <= 1'b0;
      flit_q  <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      valid_q <= valid_d;
      flit_q  <= flit_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign valid_o       = valid_q;
  assign flit_o        = flit_q;
  assign mux_out_sel_o = sel_q;
  assign last_o        = last_q;
  assign err_o         = err_q;

endmodule

// File: doc/xy_router_wh.md
Name: xy_router_wh

Overview:
- Wormhole-aware successor of the combinational XY route decoder; one instance per router input port.
- Accepts flits over a valid/ready handshake and computes the XY output direction from the head flit.
- Locks that direction for all body flits until the tail flit.
- Presents each flit with its direction select through a one-entry registered output stage to the crossbar/arbiter.

Parameters:
- X_CORD, 0, X coordinate of this router.
- Y_CORD, 0, Y coordinate of this router.
- PACKET_ADDR_X_W, 4, width of the destination X field.
- PACKET_ADDR_Y_W, 4, width of the destination Y field.
- FLIT_W, 16, total flit width; must be >= PACKET_ADDR_X_W+PACKET_ADDR_Y_W+2.
- OUTPUT_N_W, 3, width of the direction select.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- flit_i  input  FLIT_W  incoming flit.
- valid_i  input  1  flit_i valid.
- ready_o  output  1  block accepts flit_i this cycle.
- flit_o  output  FLIT_W  registered flit.
- valid_o  output  1  flit_o valid.
- ready_i  input  1  downstream accepts flit_o.
- mux_out_sel_o  output  OUTPUT_N_W  direction for flit_o.
- last_o  output  1  flit_o is a tail or single flit (releases the arbiter).
- err_o  output  1  one-cycle protocol-error pulse.

Behaviour:
- Clock and reset: one clock (clk_i); reset (rst_i) is synchronous and active-high.
- Flit type = flit_i[FLIT_W-1:FLIT_W-2]:
  - 2'b10 head.
  - 2'b00 body.
  - 2'b01 tail.
  - 2'b11 single (head+tail).
- Destination fields:
  - x_addr = flit_i[PACKET_ADDR_X_W-1:0].
  - y_addr = flit_i[PACKET_ADDR_X_W+PACKET_ADDR_Y_W-1:PACKET_ADDR_X_W].
- Direction encoding: RESOURCE=0, WEST=1, EAST=2, NORTH=3, SOUTH=4.
- XY rule (unsigned compares):
  - x_addr>X_CORD -> EAST.
  - x_addr<X_CORD -> WEST.
  - Otherwise y_addr>Y_CORD -> NORTH, y_addr<Y_CORD -> SOUTH, equal -> RESOURCE.
- Handshakes:
  - Input transfer = valid_i & ready_o.
  - ready_o = !valid_o | ready_i, combinational, full throughput.
  - Output transfer = valid_o & ready_i.
  - flit_o, mux_out_sel_o and last_o hold stable while valid_o & !ready_i.
- Latency: accepted flit appears on flit_o the next cycle.
- FSM states IDLE, PKT:
  - IDLE + head accepted -> compute direction, store in route_q, output it; go to PKT.
  - IDLE + single accepted -> compute direction, output with last_o=1; stay IDLE.
  - IDLE + body/tail accepted -> flit dropped (valid_o not set by it), err_o=1 next cycle; stay IDLE.
  - PKT + body accepted -> output with route_q; stay PKT.
  - PKT + tail accepted -> output with route_q, last_o=1; go to IDLE.
  - PKT + head/single accepted -> err_o=1; flit forwarded on route_q as a body flit (single forwarded as tail, returns to IDLE); route_q unchanged.
- Routing decision uses only the accepted flit; no decision changes without an input transfer.
- Reset values: valid_o=0, flit_o=0, mux_out_sel_o=0, last_o=0, err_o=0, route_q=0, state IDLE. ready_o=1 in the cycle after reset.
- Reset mid-packet: the packet is abandoned, state returns to IDLE, and the held output flit is discarded. A following body flit is then an error.
- Simultaneous output and input transfer in the same cycle: the register is reloaded with no bubble.

Optional Feature:
- Macro XY_ROUTER_YX_FIRST_EN:
  - Defined: dimension order is YX; Y is resolved first (NORTH/SOUTH), then X (EAST/WEST), then RESOURCE.
  - Undefined: XY order as above.
- Handshake, FSM and error behaviour are identical in both cases.

Test Plan:
- X_CORD=1, Y_CORD=1, single flits (x,y) = (3,1), (0,1), (1,3), (1,0), (1,1) -> mux_out_sel_o 2, 1, 3, 4, 0, each one cycle after acceptance, last_o=1.
- Head (3,0), two body, tail with ready_i=1 -> four consecutive valid_o cycles, all sel=2, last_o only on the tail. With XY_ROUTER_YX_FIRST_EN defined, all sel=4.
- Head then body with ready_i=0 for 3 cycles -> ready_o=0, flit_o/sel held stable. On ready_i=1 the body flows next cycle with no flit lost or duplicated.
- Body flit in IDLE -> no valid_o, err_o high exactly one cycle. Subsequent single (1,1) -> sel=0.
- Head (0,2) then head (2,2) mid-packet -> err_o pulse, second flit forwarded with sel=1, then tail closes the packet.
- rst_i asserted after head, before tail -> valid_o=0 next cycle. Following head (1,2) routed sel=3 with no error.
